qkd_mem_port_arbiter: RTL and testbench
=======================================

Name: qkd_mem_port_arbiter

Overview:
- Shares one on-chip memory slave port (11-bit word address, 16-bit data, 2-bit byteenable, clken/chipselect/write) between two requesters.
- Requester 0 is the QKD detection-event writer; requester 1 is the sifting/readout engine.
- Round-robin arbitration with bounded burst locking, registered command issue and tagged read-data return.
- One instance sits in front of each memory port exported by the SoC (mem1_s1, mem2_s1).

Parameters:
- ADDR_W, 11, memory word address width
- DATA_W, 16, memory data width; byteenable width is DATA_W/8
- READ_LATENCY, 1, cycles from chipselect-high read command to valid readdata at memory port (1..3)
- MAX_BURST, 8, maximum consecutive grants to a locking requester while the other is waiting (2..16)

Ports:
- clk_clk  in  1  single clock for all logic
- reset_reset  in  1  asynchronous, active-high reset
- rq0_valid / rq1_valid  in  1  request valid
- rq0_ready / rq1_ready  out  1  request accepted this cycle
- rq0_write / rq1_write  in  1  1 = write, 0 = read
- rq0_lock / rq1_lock  in  1  request to keep grant for next beat
- rq0_address / rq1_address  in  ADDR_W  word address
- rq0_writedata / rq1_writedata  in  DATA_W  write data
- rq0_byteenable / rq1_byteenable  in  DATA_W/8  byte enables
- rq0_rvalid / rq1_rvalid  out  1  read data valid, one-cycle pulse
- rq0_rdata / rq1_rdata  out  DATA_W  read data
- mem_s1_address  out  ADDR_W  to memory
- mem_s1_clken  out  1  to memory
- mem_s1_chipselect  out  1  to memory
- mem_s1_write  out  1  to memory
- mem_s1_writedata  out  DATA_W  to memory
- mem_s1_byteenable  out  DATA_W/8  to memory
- mem_s1_readdata  in  DATA_W  from memory

Behaviour:
- Reset: all outputs 0.
  - rr pointer = 0, so requester 0 is favoured first.
  - Burst counter = 0; read tag pipeline cleared.
  - mem_s1_clken goes 1 on the first clock after reset deassertion and stays 1.
- Acceptance:
  - At most one request accepted per cycle.
  - rqN_ready is combinational from rqN_valid and registered arbiter state.
  - Ready is never asserted without valid.
  - A request transfers when valid & ready.
  - Requesters must hold all fields stable while valid & !ready.
- Arbitration:
  - Only one valid: it wins, unless a lock cap applies.
  - Both valid: the rr pointer's requester wins.
  - After a grant to N, the pointer moves to the other requester, unless a lock is held.
- Lock:
  - If the winner had lock=1 on its accepted beat, it keeps priority next cycle and the burst counter increments.
  - Once the counter reaches MAX_BURST while the other requester is valid, the other requester is granted next and the counter clears.
  - A winner with lock=0, or an idle cycle, clears the counter.
  - No cap applies when the other requester is idle; the counter saturates at MAX_BURST.
- Issue: the accepted beat at cycle T drives mem_s1_* registered at T+1.
  - chipselect=1 for exactly one cycle per beat.
  - write, address, writedata and byteenable are copied from the beat.
  - When chipselect=0: write=0, and address/data/byteenable hold their previous values.
- Read return:
  - An owner tag shifts through a READ_LATENCY+1 deep pipeline.
  - mem_s1_readdata is sampled at T+1+READ_LATENCY and registered.
  - rqN_rvalid pulses at T+2+READ_LATENCY with rqN_rdata. Default latency is 3 cycles from acceptance.
  - rdata holds its last value otherwise.
  - The non-owner's rvalid stays 0.
  - Writes produce no rvalid.
- Ordering: returns follow acceptance order; back-to-back reads return on consecutive cycles with no bubbles.
- Throughput: 1 beat/cycle sustained; a write directly after a read needs no turnaround.
- Reset mid-operation:
  - Outstanding reads are discarded; no rvalid is produced after reset.
  - chipselect drops asynchronously.

Test Plan:
- Reset, then rq0 writes 0xA5A5 to 0x010 with byteenable 0b11 -> rq0_ready at T; mem chipselect=1, write=1, address=0x010 at T+1; no rvalid.
- rq1 reads 0x010 after that write, with memory returning 0xA5A5 -> rq1_rvalid one-cycle pulse with rdata=0xA5A5 at T+3; rq0_rvalid stays 0.
- Both valid every cycle, lock=0, 6 beats -> grants alternate 0,1,0,1,0,1 starting with rq0; chipselect high 6 consecutive cycles.
- rq0 lock=1 continuously, rq1 valid -> rq0 gets 8 consecutive grants, then rq1 1 grant, then rq0 resumes; with rq1 idle, rq0 is granted 20 beats uninterrupted.
- Interleaved reads 0x001 (rq0), 0x002 (rq1), 0x003 (rq0) with READ_LATENCY=2 -> rvalids at T+4, T+5, T+6 routed to 0, 1, 0 with matching data.
- Assert reset_reset one cycle after a read is accepted -> all outputs 0 immediately; no rvalid after release; first post-reset tie is won by rq0.

Source files
------------

// File: rtl/qkd_mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of one on-chip memory slave port:
// bounded lock bursts, registered command issue and owner-tagged read return.
module qkd_mem_port_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 8
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                rq0_valid,
  output logic                rq0_ready,
  input  logic                rq0_write,
  input  logic                rq0_lock,
  input  logic [ADDR_W-1:0]   rq0_address,
  input  logic [DATA_W-1:0]   rq0_writedata,
  input  logic [DATA_W/8-1:0] rq0_byteenable,
  output logic                rq0_rvalid,
  output logic [DATA_W-1:0]   rq0_rdata,
  input  logic                rq1_valid,
  output logic                rq1_ready,
  input  logic                rq1_write,
  input  logic                rq1_lock,
  input  logic [ADDR_W-1:0]   rq1_address,
  input  logic [DATA_W-1:0]   rq1_writedata,
  input  logic [DATA_W/8-1:0] rq1_byteenable,
  output logic                rq1_rvalid,
  output logic [DATA_W-1:0]   rq1_rdata,
  output logic [ADDR_W-1:0]   mem_s1_address,
  output logic                mem_s1_clken,
  output logic                mem_s1_chipselect,
  output logic                mem_s1_write,
  output logic [DATA_W-1:0]   mem_s1_writedata,
  output logic [DATA_W/8-1:0] mem_s1_byteenable,
  input  logic [DATA_W-1:0]   mem_s1_readdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                  rr_ptr_r;
  logic [CNT_W-1:0]      burst_cnt_r;
  logic                  ptr_valid_s;
  logic                  other_valid_s;
  logic                  cap_s;
  logic                  grant_s;
  logic                  win_s;
  logic                  sel_write_s;
  logic                  sel_lock_s;
  logic [ADDR_W-1:0]     sel_addr_s;
  logic [DATA_W-1:0]     sel_wdata_s;
  logic [BE_W-1:0]       sel_be_s;
  logic [READ_LATENCY:0] tag_valid_r;
  logic [READ_LATENCY:0] tag_owner_r;
  logic                  ret_valid_s;
  logic                  ret_owner_s;
  logic                  cs_r;
  logic                  we_r;
  logic                  clken_r;
  logic [ADDR_W-1:0]     addr_r;
  logic [DATA_W-1:0]     wdata_r;
  logic [BE_W-1:0]       be_r;
  logic                  rvalid0_r;
  logic                  rvalid1_r;
  logic [DATA_W-1:0]     rdata0_r;
  logic [DATA_W-1:0]     rdata1_r;

  // Winner selection: an expired burst yields to a waiting peer, else the favoured requester, else the other.
  always_comb begin
    ptr_valid_s   = rr_ptr_r ? rq1_valid : rq0_valid;
    other_valid_s = rr_ptr_r ? rq0_valid : rq1_valid;
    cap_s         = 1'b0;
    grant_s       = 1'b0;
    win_s         = rr_ptr_r;
    if (reset_reset) begin
      grant_s = 1'b0;
    end else if ((burst_cnt_r == CNT_MAX) && other_valid_s) begin
      cap_s   = 1'b1;
      grant_s = 1'b1;
      win_s   = ~rr_ptr_r;
    end else if (ptr_valid_s) begin
      grant_s = 1'b1;
      win_s   = rr_ptr_r;
    end else if (other_valid_s) begin
      grant_s = 1'b1;
      win_s   = ~rr_ptr_r;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign rq0_ready = grant_s & ~win_s;
  assign rq1_ready = grant_s & win_s;

  // Beat multiplexer: fields of the winning requester.
  always_comb begin
    if (win_s) begin
      sel_write_s = rq1_write;
      sel_lock_s  = rq1_lock;
      sel_addr_s  = rq1_address;
      sel_wdata_s = rq1_writedata;
      sel_be_s    = rq1_byteenable;
    end else begin
      sel_write_s = rq0_write;
      sel_lock_s  = rq0_lock;
      sel_addr_s  = rq0_address;
      sel_wdata_s = rq0_writedata;
      sel_be_s    = rq0_byteenable;
    end
  end

  // Round-robin pointer and burst counter; a locked winner keeps priority until capped.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rr_ptr_r    <= 1'b0;
      burst_cnt_r <= {CNT_W{1'b0}};
    end else if (!grant_s) begin
      burst_cnt_r <= {CNT_W{1'b0}};
    end else if (!sel_lock_s) begin
      rr_ptr_r    <= ~win_s;
      burst_cnt_r <= {CNT_W{1'b0}};
    end else begin
      rr_ptr_r <= win_s;
      if (cap_s) begin
        burst_cnt_r <= {CNT_W{1'b0}};
      end else if (win_s != rr_ptr_r) begin
        burst_cnt_r <= CNT_ONE;
      end else if (burst_cnt_r != CNT_MAX) begin
        burst_cnt_r <= burst_cnt_r + CNT_ONE;
      end else begin
        burst_cnt_r <= burst_cnt_r;
      end
    end
  end

  // Command issue register: one chipselect cycle per beat, payload held while idle.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      clken_r <= 1'b0;
      cs_r    <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      be_r    <= {BE_W{1'b0}};
    end else begin
      clken_r <= 1'b1;
      cs_r    <= grant_s;
      we_r    <= grant_s & sel_write_s;
      if (grant_s) begin
        addr_r  <= sel_addr_s;
        wdata_r <= sel_wdata_s;
        be_r    <= sel_be_s;
      end
    end
  end

  assign ret_valid_s = tag_valid_r[READ_LATENCY];
  assign ret_owner_s = tag_owner_r[READ_LATENCY];

  // Read tag pipeline; the oldest stage lines up with readdata and routes it to its owner.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      tag_valid_r <= {(READ_LATENCY + 1){1'b0}};
      tag_owner_r <= {(READ_LATENCY + 1){1'b0}};
      rvalid0_r   <= 1'b0;
      rvalid1_r   <= 1'b0;
      rdata0_r    <= {DATA_W{1'b0}};
      rdata1_r    <= {DATA_W{1'b0}};
    end else begin
      tag_valid_r <= {tag_valid_r[READ_LATENCY-1:0], grant_s & ~sel_write_s};
      tag_owner_r <= {tag_owner_r[READ_LATENCY-1:0], win_s};
      rvalid0_r   <= ret_valid_s & ~ret_owner_s;
      rvalid1_r   <= ret_valid_s & ret_owner_s;
      if (ret_valid_s && !ret_owner_s) begin
        rdata0_r <= mem_s1_readdata;
      end
      if (ret_valid_s && ret_owner_s) begin
        rdata1_r <= mem_s1_readdata;
      end
    end
  end

  assign mem_s1_clken      = clken_r;
  assign mem_s1_chipselect = cs_r;
  assign mem_s1_write      = we_r;
  assign mem_s1_address    = addr_r;
  assign mem_s1_writedata  = wdata_r;
  assign mem_s1_byteenable = be_r;
  assign rq0_rvalid        = rvalid0_r;
  assign rq1_rvalid        = rvalid1_r;
  assign rq0_rdata         = rdata0_r;
  assign rq1_rdata         = rdata1_r;

endmodule

// File: tb/tb_qkd_mem_port_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a rule-level reference model.
module tb_qkd_mem_port_arbiter;

  localparam int AW = 11;
  localparam int DW = 16;
  localparam int BW = 2;
  localparam int RL = 1;
  localparam int MB = 8;

  logic clk_clk = 1'b0;
  logic reset_reset = 1'b1;
  logic rq0_valid, rq0_write, rq0_lock, rq0_ready, rq0_rvalid;
  logic rq1_valid, rq1_write, rq1_lock, rq1_ready, rq1_rvalid;
  logic [AW-1:0] rq0_address, rq1_address, mem_s1_address;
  logic [DW-1:0] rq0_writedata, rq1_writedata, rq0_rdata, rq1_rdata;
  logic [BW-1:0] rq0_byteenable, rq1_byteenable, mem_s1_byteenable;
  logic mem_s1_clken, mem_s1_chipselect, mem_s1_write;
  logic [DW-1:0] mem_s1_writedata, mem_s1_readdata;

  qkd_mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .MAX_BURST(MB)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_write(rq0_write), .rq0_lock(rq0_lock),
    .rq0_address(rq0_address), .rq0_writedata(rq0_writedata), .rq0_byteenable(rq0_byteenable),
    .rq0_rvalid(rq0_rvalid), .rq0_rdata(rq0_rdata),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_write(rq1_write), .rq1_lock(rq1_lock),
    .rq1_address(rq1_address), .rq1_writedata(rq1_writedata), .rq1_byteenable(rq1_byteenable),
    .rq1_rvalid(rq1_rvalid), .rq1_rdata(rq1_rdata),
    .mem_s1_address(mem_s1_address), .mem_s1_clken(mem_s1_clken),
    .mem_s1_chipselect(mem_s1_chipselect), .mem_s1_write(mem_s1_write),
    .mem_s1_writedata(mem_s1_writedata), .mem_s1_byteenable(mem_s1_byteenable),
    .mem_s1_readdata(mem_s1_readdata)
  );

  always #5 clk_clk = ~clk_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    return 16'(i) * 16'h1111;
  endfunction

  // Memory slave: byte-enabled writes, reads return READ_LATENCY cycles after the command.
  logic [DW-1:0] ram [0:2047];
  logic [DW-1:0] rd_pipe [0:RL-1];
  logic ram_init = 1'b0;
  always @(posedge clk_clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 2048; i++) ram[i] <= init_val(i);
      ram_init <= 1'b1;
    end else if (mem_s1_chipselect && mem_s1_write) begin
      if (mem_s1_byteenable[0]) ram[mem_s1_address][7:0]  <= mem_s1_writedata[7:0];
      if (mem_s1_byteenable[1]) ram[mem_s1_address][15:8] <= mem_s1_writedata[15:8];
    end
    rd_pipe[0] <= ram[mem_s1_address];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_s1_readdata = rd_pipe[RL-1];

  // Reference model state: favoured requester, locked run length, shadow memory, return schedule.
  logic [DW-1:0] shadow [0:2047];
  logic sh_init = 1'b0;
  int cyc = 0;
  int m_fav = 0, m_run = 0, m_w, m_slot;
  bit m_cap, m_vf, m_vo, m_wr, m_lk;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;
  logic [BW-1:0] m_be;
  logic e_cs = 1'b0, e_we = 1'b0, e_clken = 1'b0, e_rv0, e_rv1;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wd = '0, e_rd0 = '0, e_rd1 = '0;
  logic [BW-1:0] e_be = '0;
  bit ret_v [0:7];
  int ret_o [0:7];
  logic [DW-1:0] ret_d [0:7];

  always @(negedge clk_clk) begin
    if (!sh_init) begin
      for (int i = 0; i < 2048; i++) shadow[i] = init_val(i);
      for (int i = 0; i < 8; i++) ret_v[i] = 1'b0;
      sh_init = 1'b1;
    end
    if (reset_reset) begin
      chk("rst_ctrl", {rq0_ready, rq1_ready, rq0_rvalid, rq1_rvalid,
                       mem_s1_chipselect, mem_s1_write, mem_s1_clken}, 32'd0);
      chk("rst_cmd", {mem_s1_address, mem_s1_byteenable}, 32'd0);
      chk("rst_wdata", mem_s1_writedata, 32'd0);
      chk("rst_rdata", {rq0_rdata, rq1_rdata}, 32'd0);
      for (int i = 0; i < 8; i++) ret_v[i] = 1'b0;
      m_fav = 0; m_run = 0;
      e_cs = 1'b0; e_we = 1'b0; e_clken = 1'b0;
      e_addr = '0; e_wd = '0; e_be = '0; e_rd0 = '0; e_rd1 = '0;
    end else begin
      chk("clken", mem_s1_clken, e_clken);
      chk("cs", mem_s1_chipselect, e_cs);
      chk("we", mem_s1_write, e_we);
      chk("addr", mem_s1_address, e_addr);
      chk("wdata", mem_s1_writedata, e_wd);
      chk("be", mem_s1_byteenable, e_be);
      m_slot = cyc % 8;
      e_rv0 = ret_v[m_slot] && ret_o[m_slot] == 0;
      e_rv1 = ret_v[m_slot] && ret_o[m_slot] == 1;
      if (e_rv0) e_rd0 = ret_d[m_slot];
      if (e_rv1) e_rd1 = ret_d[m_slot];
      ret_v[m_slot] = 1'b0;
      chk("rvalid0", rq0_rvalid, e_rv0);
      chk("rvalid1", rq1_rvalid, e_rv1);
      chk("rdata0", rq0_rdata, e_rd0);
      chk("rdata1", rq1_rdata, e_rd1);
      m_vf = (m_fav == 0) ? rq0_valid : rq1_valid;
      m_vo = (m_fav == 0) ? rq1_valid : rq0_valid;
      m_cap = 1'b0;
      if (!m_vf && !m_vo) m_w = -1;
      else if (m_run >= MB && m_vo) begin m_w = 1 - m_fav; m_cap = 1'b1; end
      else if (m_vf) m_w = m_fav;
      else m_w = 1 - m_fav;
      chk("ready0", rq0_ready, m_w == 0);
      chk("ready1", rq1_ready, m_w == 1);
      e_clken = 1'b1;
      if (m_w < 0) begin
        e_cs = 1'b0; e_we = 1'b0; m_run = 0;
      end else begin
        m_wr = (m_w == 0) ? rq0_write : rq1_write;
        m_lk = (m_w == 0) ? rq0_lock : rq1_lock;
        m_a  = (m_w == 0) ? rq0_address : rq1_address;
        m_d  = (m_w == 0) ? rq0_writedata : rq1_writedata;
        m_be = (m_w == 0) ? rq0_byteenable : rq1_byteenable;
        e_cs = 1'b1; e_we = m_wr; e_addr = m_a; e_wd = m_d; e_be = m_be;
        if (m_wr) begin
          if (m_be[0]) shadow[m_a][7:0]  = m_d[7:0];
          if (m_be[1]) shadow[m_a][15:8] = m_d[15:8];
        end else begin
          ret_v[(cyc + 2 + RL) % 8] = 1'b1;
          ret_o[(cyc + 2 + RL) % 8] = m_w;
          ret_d[(cyc + 2 + RL) % 8] = shadow[m_a];
        end
        if (m_cap || !m_lk) m_run = 0;
        else if (m_w == m_fav) m_run = (m_run < MB) ? m_run + 1 : MB;
        else m_run = 1;
        m_fav = m_lk ? m_w : 1 - m_w;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic drive(input int n, input logic v, input logic w, input logic l,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    if (n == 0) begin
      rq0_valid = v; rq0_write = w; rq0_lock = l; rq0_address = a; rq0_writedata = d; rq0_byteenable = be;
    end else begin
      rq1_valid = v; rq1_write = w; rq1_lock = l; rq1_address = a; rq1_writedata = d; rq1_byteenable = be;
    end
  endtask

  int g [0:15];
  int cnt;
  logic [3:0] lg [0:7];
  logic [DW-1:0] ld0 [0:7];
  logic [DW-1:0] ld1 [0:7];
  bit hold0, hold1;
  int vp0, vp1, lp0, lp1;

  initial begin
    drive(0, 1'b1, 1'b1, 1'b0, 11'h055, 16'h1234, 2'b11);
    drive(1, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000, 2'b00);
    repeat (3) tick();
    @(negedge clk_clk);
    chk("init_ready_gated", rq0_ready, 1'b0);
    chk("init_cs", mem_s1_chipselect, 1'b0);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000, 2'b00);
    reset_reset = 1'b0;
    @(negedge clk_clk);
    chk("clken_first", mem_s1_clken, 1'b0);
    tick();
    @(negedge clk_clk);
    chk("clken_on", mem_s1_clken, 1'b1);

    // rq0 single write
    tick();
    drive(0, 1'b1, 1'b1, 1'b0, 11'h010, 16'hA5A5, 2'b11);
    @(negedge clk_clk);
    chk("t1_ready", rq0_ready, 1'b1);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000, 2'b00);
    @(negedge clk_clk);
    chk("t1_issue", {mem_s1_chipselect, mem_s1_write, mem_s1_address}, {2'b11, 11'h010});
    chk("t1_data", {mem_s1_writedata, mem_s1_byteenable}, {16'hA5A5, 2'b11});
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk_clk);
      chk("t1_no_rv", {rq0_rvalid, rq1_rvalid}, 2'b00);
    end

    // rq1 reads back
    tick();
    drive(1, 1'b1, 1'b0, 1'b0, 11'h010, 16'h0000, 2'b11);
    @(negedge clk_clk);
    chk("t2_ready", rq1_ready, 1'b1);
    tick();
    drive(1, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000, 2'b00);
    for (int k = 1; k <= RL + 3; k++) begin
      @(negedge clk_clk);
      if (k == RL + 2) begin
        chk("t2_rvalid", {rq0_rvalid, rq1_rvalid}, 2'b01);
        chk("t2_rdata", rq1_rdata, 16'hA5A5);
      end else begin
        chk("t2_rv_pulse", {rq0_rvalid, rq1_rvalid}, 2'b00);
      end
      tick();
    end

    // alternation, both valid, no lock
    drive(0, 1'b1, 1'b1, 1'b0, 11'h100, 16'h0100, 2'b11);
    drive(1, 1'b1, 1'b1, 1'b0, 11'h101, 16'h0101, 2'b11);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_clk);
      cnt += int'(mem_s1_chipselect);
      if (k < 6) begin
        g[k] = rq1_ready ? 1 : 0;
        chk("t3_onehot", {rq0_ready, rq1_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
      end
      tick();
      if (k == 5) begin
        drive(0, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000, 2'b00);
        drive(1, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000, 2'b00);
      end
    end
    for (int k = 0; k < 6; k++) chk("t3_grant", g[k], k % 2);
    chk("t3_cs_count", cnt, 6);

    // lock burst cap
    drive(0, 1'b1, 1'b1, 1'b1, 11'h200, 16'h0200, 2'b11);
    drive(1, 1'b1, 1'b1, 1'b0, 11'h201, 16'h0201, 2'b11);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_clk);
      g[k] = rq1_ready ? 1 : 0;
      tick();
    end
    for (int k = 0; k < 12; k++) chk("t4_lock_grant", g[k], (k == MB) ? 1 : 0);
    drive(1, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000, 2'b00);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_clk);
      cnt += int'(rq0_ready);
      tick();
    end
    chk("t4_uncapped", cnt, 20);
    drive(0, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000, 2'b00);
    repeat (3) tick();

    // interleaved reads
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin
        drive(0, 1'b1, 1'b0, 1'b0, 11'h001, 16'h0000, 2'b11);
        drive(1, 1'b1, 1'b0, 1'b0, 11'h002, 16'h0000, 2'b11);
      end else if (k == 1) begin
        drive(0, 1'b1, 1'b0, 1'b0, 11'h003, 16'h0000, 2'b11);
      end else if (k == 2) begin
        drive(1, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000, 2'b00);
      end else if (k == 3) begin
        drive(0, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000, 2'b00);
      end
      @(negedge clk_clk);
      lg[k] = {rq0_ready, rq1_ready, rq0_rvalid, rq1_rvalid};
      ld0[k] = rq0_rdata;
      ld1[k] = rq1_rdata;
      tick();
    end
    chk("t5_acc0", lg[0][3:2], 2'b10);
    chk("t5_acc1", lg[1][3:2], 2'b01);
    chk("t5_acc2", lg[2][3:2], 2'b10);
    for (int k = 0; k < 8; k++)
      chk("t5_rv", lg[k][1:0], (k == 2 + RL || k == 4 + RL) ? 2'b10 : ((k == 3 + RL) ? 2'b01 : 2'b00));
    chk("t5_d0", ld0[2 + RL], 16'h1111);
    chk("t5_d1", ld1[3 + RL], 16'h2222);
    chk("t5_d2", ld0[4 + RL], 16'h3333);

    // reset with a read in flight
    drive(0, 1'b1, 1'b0, 1'b0, 11'h001, 16'h0000, 2'b11);
    @(negedge clk_clk);
    chk("t6_acc", rq0_ready, 1'b1);
    tick();
    reset_reset = 1'b1;
    drive(0, 1'b1, 1'b1, 1'b0, 11'h300, 16'h3000, 2'b11);
    drive(1, 1'b1, 1'b1, 1'b0, 11'h301, 16'h3001, 2'b11);
    @(negedge clk_clk);
    chk("t6_rst_ctrl", {rq0_ready, rq1_ready, rq0_rvalid, rq1_rvalid, mem_s1_chipselect, mem_s1_clken}, 6'd0);
    chk("t6_rst_addr", mem_s1_address, 11'h000);
    tick();
    tick();
    reset_reset = 1'b0;
    @(negedge clk_clk);
    chk("t6_tie", {rq0_ready, rq1_ready}, 2'b10);
    cnt = int'(rq0_rvalid) + int'(rq1_rvalid);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000, 2'b00);
    drive(1, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000, 2'b00);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_clk);
      cnt += int'(rq0_rvalid) + int'(rq1_rvalid);
      tick();
    end
    chk("t6_no_rv", cnt, 0);

    // randomized traffic in several density/lock regimes
    hold0 = 1'b0;
    hold1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      case ((c / 600) % 5)
        0: begin vp0 = 50;  vp1 = 50;  lp0 = 10;  lp1 = 10; end
        1: begin vp0 = 90;  vp1 = 90;  lp0 = 70;  lp1 = 70; end
        2: begin vp0 = 100; vp1 = 30;  lp0 = 100; lp1 = 20; end
        3: begin vp0 = 100; vp1 = 100; lp0 = 50;  lp1 = 50; end
        default: begin vp0 = 25; vp1 = 25; lp0 = 40; lp1 = 40; end
      endcase
      if (!hold0)
        drive(0, $urandom_range(0, 99) < vp0, 1'($urandom), $urandom_range(0, 99) < lp0,
              11'($urandom_range(0, 15)), 16'($urandom), 2'($urandom));
      if (!hold1)
        drive(1, $urandom_range(0, 99) < vp1, 1'($urandom), $urandom_range(0, 99) < lp1,
              11'($urandom_range(0, 15)), 16'($urandom), 2'($urandom));
      reset_reset = ($urandom_range(0, 399) == 0);
      @(negedge clk_clk);
      hold0 = rq0_valid && !rq0_ready;
      hold1 = rq1_valid && !rq1_ready;
      tick();
    end
    reset_reset = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000, 2'b00);
    drive(1, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000, 2'b00);
    repeat (10) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
